// File: rtl/pipe_stage_elastic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pipe_stage_elastic
//  Description : Elastic pipeline stage register for the 5-stage MIPS
//                pipeline. Ready/valid handshake on both sides, a head
//                register driving the outputs and a one-entry skid register
//                that catches the in-flight instruction when the head is
//                blocked. Counts stall and flush events with saturating
//                counters. Active clock edge is selectable.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 96,
    parameter int PC_W    = 18,
    parameter int CNT_W   = 16,
    parameter bit NEGEDGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // All architectural state of the stage, updated as one vector so the
    // edge-selection logic below stays trivial.
    typedef struct packed {
        state_t            state;
        logic              out_valid;
        logic              in_ready;
        logic [CTRL_W-1:0] head_ctrl;
        logic [DATA_W-1:0] head_data;
        logic [PC_W-1:0]   head_pc;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;
        logic [PC_W-1:0]   skid_pc;
        logic [CNT_W-1:0]  stall_cnt;
        logic [CNT_W-1:0]  flush_cnt;
    } regs_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    regs_t              r_regs;
    regs_t              w_regs_nxt;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_stall_evt;
    logic [2:0]         w_flush_add;
    logic [CNT_W+1:0]   w_flush_sum;

    assign w_in_xfer   = in_valid & r_regs.in_ready;
    assign w_out_xfer  = r_regs.out_valid & out_ready;
    assign w_stall_evt = r_regs.out_valid & ~out_ready;

    // Entries discarded by a flush: held entries plus the incoming one,
    // minus a head that leaves downstream on the same edge. The incoming
    // entry counts even when the stage is full and would have ignored it.
    always_comb begin
        w_flush_add = 3'd0;
        if (flush) begin
            w_flush_add = {1'b0, r_regs.state} + {2'b00, in_valid} - {2'b00, w_out_xfer};
        end
    end

    // Single wide sum so the flush counter needs only one saturation test.
    assign w_flush_sum = {2'b00, r_regs.flush_cnt} + {{(CNT_W-1){1'b0}}, w_flush_add};

    // Next-state: occupancy FSM, head/skid loading and event counters.
    always_comb begin
        w_regs_nxt = r_regs;

        if (flush) begin
            // Kill everything; head data/PC stay visible for debug.
            w_regs_nxt.state     = ST_EMPTY;
            w_regs_nxt.head_ctrl = '0;
        end else begin
            case (r_regs.state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_regs_nxt.state     = ST_ONE;
                        w_regs_nxt.head_ctrl = in_ctrl;
                        w_regs_nxt.head_data = in_data;
                        w_regs_nxt.head_pc   = in_pc;
                    end
                end
                ST_ONE: begin
                    case ({w_in_xfer, w_out_xfer})
                        2'b11: begin
                            w_regs_nxt.head_ctrl = in_ctrl;
                            w_regs_nxt.head_data = in_data;
                            w_regs_nxt.head_pc   = in_pc;
                        end
                        2'b10: begin
                            // Head blocked: park the newcomer behind it.
                            w_regs_nxt.state     = ST_FULL;
                            w_regs_nxt.skid_ctrl = in_ctrl;
                            w_regs_nxt.skid_data = in_data;
                            w_regs_nxt.skid_pc   = in_pc;
                        end
                        2'b01: begin
                            w_regs_nxt.state     = ST_EMPTY;
                            w_regs_nxt.head_ctrl = '0;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side matters.
                    if (w_out_xfer) begin
                        w_regs_nxt.state     = ST_ONE;
                        w_regs_nxt.head_ctrl = r_regs.skid_ctrl;
                        w_regs_nxt.head_data = r_regs.skid_data;
                        w_regs_nxt.head_pc   = r_regs.skid_pc;
                    end
                end
                default: begin
                    w_regs_nxt.state     = ST_EMPTY;
                    w_regs_nxt.head_ctrl = '0;
                end
            endcase
        end

        // Handshake flags are registered copies of the next occupancy.
        w_regs_nxt.out_valid = (w_regs_nxt.state != ST_EMPTY);
        w_regs_nxt.in_ready  = (w_regs_nxt.state != ST_FULL);

        if (w_stall_evt && (r_regs.stall_cnt != c_cnt_max)) begin
            w_regs_nxt.stall_cnt = r_regs.stall_cnt + c_cnt_one;
        end

        if (w_flush_sum > {2'b00, c_cnt_max}) begin
            w_regs_nxt.flush_cnt = c_cnt_max;
        end else begin
            w_regs_nxt.flush_cnt = w_flush_sum[CNT_W-1:0];
        end
    end

    generate
        if (NEGEDGE) begin : g_negedge
            // State register clocked on the falling edge, async reset.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    r_regs          <= '0;
                    r_regs.in_ready <= 1'b1;
                end else begin
                    r_regs <= w_regs_nxt;
                end
            end
        end else begin : g_posedge
            // State register clocked on the rising edge, async reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_regs          <= '0;
                    r_regs.in_ready <= 1'b1;
                end else begin
                    r_regs <= w_regs_nxt;
                end
            end
        end
    endgenerate

    assign in_ready  = r_regs.in_ready;
    assign out_valid = r_regs.out_valid;
    assign out_ctrl  = r_regs.head_ctrl;
    assign out_data  = r_regs.head_data;
    assign out_pc    = r_regs.head_pc;
    assign occupancy = r_regs.state;
    assign stall_cnt = r_regs.stall_cnt;
    assign flush_cnt = r_regs.flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipe_stage_elastic
//  Description : Bench for pipe_stage_elastic. Two instances share stimulus:
//                one on the falling edge with 16-bit counters, one on the
//                rising edge with 2-bit counters. Expected values come from a
//                queue-based model of the stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_elastic;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic [17:0] pc;
    } ent_t;

    typedef struct {
        logic        v;
        logic        r;
        logic [1:0]  occ;
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic [17:0] pc;
        int unsigned stall;
        int unsigned fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [95:0] in_data = '0;
    logic [17:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        n_in_ready, n_out_valid;
    logic [7:0]  n_out_ctrl;
    logic [95:0] n_out_data;
    logic [17:0] n_out_pc;
    logic [1:0]  n_occ;
    logic [15:0] n_stall_cnt, n_flush_cnt;

    logic        p_in_ready, p_out_valid;
    logic [7:0]  p_out_ctrl;
    logic [95:0] p_out_data;
    logic [17:0] p_out_pc;
    logic [1:0]  p_occ;
    logic [1:0]  p_stall_cnt, p_flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.CTRL_W(8), .DATA_W(96), .PC_W(18), .CNT_W(16), .NEGEDGE(1'b1)) u_neg (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl),
        .out_data(n_out_data), .out_pc(n_out_pc), .occupancy(n_occ),
        .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    pipe_stage_elastic #(.CTRL_W(8), .DATA_W(96), .PC_W(18), .CNT_W(2), .NEGEDGE(1'b0)) u_pos (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .flush(flush),
        .out_valid(p_out_valid), .out_ready(out_ready), .out_ctrl(p_out_ctrl),
        .out_data(p_out_data), .out_pc(p_out_pc), .occupancy(p_occ),
        .stall_cnt(p_stall_cnt), .flush_cnt(p_flush_cnt)
    );

    // Reference model: FIFO of held entries, last shown head, raw event totals.
    ent_t        q[$];
    logic [95:0] sh_data;
    logic [17:0] sh_pc;
    int unsigned stall_n;
    int unsigned flush_n;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        q.delete();
        sh_data = '0;
        sh_pc   = '0;
        stall_n = 0;
        flush_n = 0;
    endtask

    task automatic model_step(input logic v, input ent_t e, input logic ordy, input logic fl);
        int occ;
        int ox;
        occ = q.size();
        ox  = (occ > 0 && ordy) ? 1 : 0;
        if (occ > 0 && !ordy) stall_n++;
        if (fl) begin
            flush_n += occ - ox + (v ? 1 : 0);
            q.delete();
        end else begin
            if (ox == 1) void'(q.pop_front());
            if (v && occ < 2) q.push_back(e);
        end
        if (q.size() > 0) begin
            sh_data = q[0].data;
            sh_pc   = q[0].pc;
        end
    endtask

    function automatic exp_t model_view(input int unsigned cmax);
        exp_t e;
        e.v     = (q.size() > 0);
        e.r     = (q.size() < 2);
        e.occ   = 2'(q.size());
        e.ctrl  = (q.size() > 0) ? q[0].ctrl : 8'h00;
        e.data  = sh_data;
        e.pc    = sh_pc;
        e.stall = (stall_n > cmax) ? cmax : stall_n;
        e.fl    = (flush_n > cmax) ? cmax : flush_n;
        return e;
    endfunction

    task automatic check_dut(input string tag, input exp_t e, input logic ov, input logic ir,
                             input logic [1:0] occ, input logic [7:0] ctrl, input logic [95:0] data,
                             input logic [17:0] pc, input logic [15:0] sc, input logic [15:0] fc);
        check_val({tag, ".out_valid"}, ov, e.v);
        check_val({tag, ".in_ready"}, ir, e.r);
        check_val({tag, ".occupancy"}, occ, e.occ);
        check_val({tag, ".out_ctrl"}, ctrl, e.ctrl);
        check_val({tag, ".out_data"}, data, e.data);
        check_val({tag, ".out_pc"}, pc, e.pc);
        check_val({tag, ".stall_cnt"}, sc, e.stall);
        check_val({tag, ".flush_cnt"}, fc, e.fl);
    endtask

    task automatic check_pos(input string tag, input exp_t e);
        check_dut(tag, e, p_out_valid, p_in_ready, p_occ, p_out_ctrl, p_out_data, p_out_pc,
                  {14'd0, p_stall_cnt}, {14'd0, p_flush_cnt});
    endtask

    task automatic check_neg(input string tag, input exp_t e);
        check_dut(tag, e, n_out_valid, n_in_ready, n_occ, n_out_ctrl, n_out_data, n_out_pc,
                  n_stall_cnt, n_flush_cnt);
    endtask

    function automatic ent_t mk(input logic [17:0] pc);
        ent_t e;
        e.ctrl = 8'($urandom);
        e.data = {$urandom, $urandom, $urandom};
        e.pc   = pc;
        return e;
    endfunction

    // One full clock period, entered and left 1 time unit after a falling edge.
    task automatic cycle(input logic v, input ent_t e, input logic ordy, input logic fl);
        exp_t pre_n, post_n, post_p;
        in_valid  = v;
        in_ctrl   = e.ctrl;
        in_data   = e.data;
        in_pc     = e.pc;
        out_ready = ordy;
        flush     = fl;
        pre_n  = model_view(32'd65535);
        model_step(v, e, ordy, fl);
        post_n = model_view(32'd65535);
        post_p = model_view(32'd3);
        #5;
        check_pos("pos_after_rise", post_p);
        check_neg("neg_after_rise", pre_n);
        #5;
        check_pos("pos_after_fall", post_p);
        check_neg("neg_after_fall", post_n);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_pos("pos_mid_reset", model_view(32'd3));
        check_neg("neg_mid_reset", model_view(32'd65535));
        rst = 1'b0;
        #8;
    endtask

    initial begin
        ent_t e;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_pos("pos_reset", model_view(32'd3));
        check_neg("neg_reset", model_view(32'd65535));
        rst = 1'b0;

        // Streaming with downstream always ready
        cycle(1'b1, mk(18'h004), 1'b1, 1'b0);
        cycle(1'b1, mk(18'h008), 1'b1, 1'b0);
        cycle(1'b1, mk(18'h00C), 1'b1, 1'b0);
        check_val("stream.out_pc", n_out_pc, 18'h00C);
        check_val("stream.stall_cnt", n_stall_cnt, 16'd0);
        cycle(1'b0, mk(18'h000), 1'b1, 1'b0);

        // Backpressure: fill, offer a third entry, then drain in order
        cycle(1'b1, mk(18'h010), 1'b0, 1'b0);
        cycle(1'b1, mk(18'h014), 1'b0, 1'b0);
        cycle(1'b1, mk(18'h018), 1'b0, 1'b0);
        check_val("bp.in_ready", n_in_ready, 1'b0);
        check_val("bp.head_pc", n_out_pc, 18'h010);
        cycle(1'b0, mk(18'h000), 1'b1, 1'b0);
        check_val("bp.second_pc", n_out_pc, 18'h014);
        cycle(1'b0, mk(18'h000), 1'b1, 1'b0);

        // Flush while full with a valid incoming control bundle of all ones
        cycle(1'b1, mk(18'h010), 1'b0, 1'b0);
        cycle(1'b1, mk(18'h014), 1'b0, 1'b0);
        e = mk(18'h01C);
        e.ctrl = 8'hFF;
        cycle(1'b1, e, 1'b0, 1'b1);
        check_val("flush.flush_cnt", n_flush_cnt, 16'd3);
        check_val("flush.out_pc", n_out_pc, 18'h010);
        check_val("flush.out_ctrl", n_out_ctrl, 8'h00);

        // Stall counter saturation on the 2-bit instance
        cycle(1'b1, mk(18'h020), 1'b0, 1'b0);
        repeat (6) cycle(1'b0, mk(18'h000), 1'b0, 1'b0);
        check_val("sat.stall_cnt", {14'd0, p_stall_cnt}, 16'd3);
        cycle(1'b0, mk(18'h000), 1'b1, 1'b0);

        // Reset arriving while full
        cycle(1'b1, mk(18'h024), 1'b0, 1'b0);
        cycle(1'b1, mk(18'h028), 1'b0, 1'b0);
        mid_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 9) < 7, mk(18'($urandom)),
                      $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
